// File: rtl/chacha20_keystream_xor.sv
// Keystream buffer and XOR engine: fetches 512-bit ChaCha20 blocks by counter, buffers
// up to KS_DEPTH of them and XORs DATA_W-wide lanes onto a valid/ready payload stream.
module chacha20_keystream_xor #(
  parameter int DATA_W   = 32,
  parameter int KS_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         init_counter,
  output logic                ks_req,
  output logic [31:0]         ks_counter,
  input  logic                ks_valid,
  output logic                ks_ready,
  input  logic [511:0]        ks_block,
  input  logic                din_valid,
  output logic                din_ready,
  input  logic [DATA_W-1:0]   din_data,
  input  logic [DATA_W/8-1:0] din_keep,
  input  logic                din_last,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [DATA_W-1:0]   dout_data,
  output logic [DATA_W/8-1:0] dout_keep,
  output logic                dout_last,
  output logic                busy,
  output logic                ctr_overflow
);

  localparam int WORDS  = 512 / DATA_W;
  localparam int KEEP_W = DATA_W / 8;
  localparam int LP_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int FP_W   = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
  localparam int CNT_W  = $clog2(KS_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  // Handshakes: a transfer happens on any rising edge where valid && ready; valid never
  // waits on ready, and once raised ks_req/dout_valid hold until their transfer completes.
  state_t              state_q, state_d;
  logic [511:0]        fifo_q [KS_DEPTH];
  logic [511:0]        fifo_d [KS_DEPTH];
  logic [FP_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [LP_W-1:0]     lane_ptr_q, lane_ptr_d;
  logic                ks_req_q, ks_req_d;
  logic [31:0]         ks_counter_q, ks_counter_d;
  logic                ctr_overflow_q, ctr_overflow_d;
  logic                dout_valid_q, dout_valid_d;
  logic [DATA_W-1:0]   dout_data_q, dout_data_d;
  logic [KEEP_W-1:0]   dout_keep_q, dout_keep_d;
  logic                dout_last_q, dout_last_d;

  logic [WORDS-1:0][DATA_W-1:0] head_lanes;
  logic [DATA_W-1:0]   lane_ks;
  logic [KEEP_W-1:0]   keep_eff;
  logic [DATA_W-1:0]   keep_mask;
  logic                ks_hs, beat_acc, last_acc, push, pop;

  function automatic logic [FP_W-1:0] fp_inc(input logic [FP_W-1:0] p);
    return (p == FP_W'(KS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_lanes = fifo_q[rd_ptr_q];
  assign lane_ks    = head_lanes[lane_ptr_q];
  assign keep_eff   = din_last ? din_keep : '1;

  always_comb begin
    keep_mask = '0;
    for (int b = 0; b < KEEP_W; b++) keep_mask[b*8 +: 8] = {8{keep_eff[b]}};
  end

  // Ready depends on dout_ready but never on din_valid.
  assign din_ready = (state_q == S_RUN) && (count_q != '0) && (!dout_valid_q || dout_ready);
  assign ks_hs     = ks_req_q && ks_valid;
  assign beat_acc  = din_valid && din_ready;
  assign last_acc  = beat_acc && din_last;
  assign push      = ks_hs && (state_q == S_RUN) && !last_acc;
  assign pop       = beat_acc && (din_last || (lane_ptr_q == LP_W'(WORDS - 1)));

  always_comb begin
    state_d        = state_q;
    fifo_d         = fifo_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    lane_ptr_d     = lane_ptr_q;
    ks_req_d       = ks_req_q;
    ks_counter_d   = ks_counter_q;
    ctr_overflow_d = ctr_overflow_q;
    dout_valid_d   = dout_valid_q;
    dout_data_d    = dout_data_q;
    dout_keep_d    = dout_keep_q;
    dout_last_d    = dout_last_q;

    case (state_q)
      S_IDLE: if (start) begin
        state_d        = S_RUN;
        ks_counter_d   = init_counter;
        ctr_overflow_d = 1'b0;
        rd_ptr_d       = '0;
        wr_ptr_d       = '0;
        count_d        = '0;
        lane_ptr_d     = '0;
      end
      S_RUN:   if (last_acc) state_d = S_DRAIN;
      S_DRAIN: if (!ks_req_q || ks_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The outstanding request counts toward occupancy, so a push can never overfill.
    if (ks_hs) begin
      ks_req_d     = 1'b0;
      ks_counter_d = ks_counter_q + 32'd1;
      if (ks_counter_q == 32'hFFFF_FFFF) ctr_overflow_d = 1'b1;
    end else if (!ks_req_q && (state_q == S_RUN) && !last_acc && !ctr_overflow_q &&
                 (count_q < CNT_W'(KS_DEPTH))) begin
      ks_req_d = 1'b1;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = ks_block;
      wr_ptr_d         = fp_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = fp_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase

    if (beat_acc) lane_ptr_d = pop ? '0 : lane_ptr_q + 1'b1;

    // End of message discards the rest of the buffered keystream.
    if (last_acc) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      lane_ptr_d = '0;
    end

    if (beat_acc) begin
      dout_valid_d = 1'b1;
      dout_data_d  = (din_data ^ lane_ks) & keep_mask;
      dout_keep_d  = keep_eff;
      dout_last_d  = din_last;
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      fifo_q         <= '{default: '0};
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      lane_ptr_q     <= '0;
      ks_req_q       <= 1'b0;
      ks_counter_q   <= '0;
      ctr_overflow_q <= 1'b0;
      dout_valid_q   <= 1'b0;
      dout_data_q    <= '0;
      dout_keep_q    <= '0;
      dout_last_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      fifo_q         <= fifo_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      lane_ptr_q     <= lane_ptr_d;
      ks_req_q       <= ks_req_d;
      ks_counter_q   <= ks_counter_d;
      ctr_overflow_q <= ctr_overflow_d;
      dout_valid_q   <= dout_valid_d;
      dout_data_q    <= dout_data_d;
      dout_keep_q    <= dout_keep_d;
      dout_last_q    <= dout_last_d;
    end
  end

  assign ks_req       = ks_req_q;
  assign ks_ready     = ks_req_q;
  assign ks_counter   = ks_counter_q;
  assign dout_valid   = dout_valid_q;
  assign dout_data    = dout_data_q;
  assign dout_keep    = dout_keep_q;
  assign dout_last    = dout_last_q;
  assign busy         = (state_q != S_IDLE);
  assign ctr_overflow = ctr_overflow_q;

endmodule

// File: tb/tb_chacha20_keystream_xor.sv
// Bench for chacha20_keystream_xor (DATA_W=32, KS_DEPTH=2): block-function responder,
// payload driver and a scoreboard that predicts each output beat from counter and lane.
module tb_chacha20_keystream_xor;
  localparam int DATA_W   = 32;
  localparam int KS_DEPTH = 2;
  localparam int WORDS    = 512 / DATA_W;
  localparam int KEEP_W   = DATA_W / 8;
  localparam int SB_W     = DATA_W + KEEP_W + 1;

  logic                clk, rst, start;
  logic [31:0]         init_counter;
  logic                ks_req, ks_valid, ks_ready;
  logic [31:0]         ks_counter;
  logic [511:0]        ks_block;
  logic                din_valid, din_ready, din_last;
  logic [DATA_W-1:0]   din_data;
  logic [KEEP_W-1:0]   din_keep;
  logic                dout_valid, dout_ready, dout_last;
  logic [DATA_W-1:0]   dout_data;
  logic [KEEP_W-1:0]   dout_keep;
  logic                busy, ctr_overflow;

  chacha20_keystream_xor #(.DATA_W(DATA_W), .KS_DEPTH(KS_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .init_counter(init_counter),
    .ks_req(ks_req), .ks_counter(ks_counter), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .ks_block(ks_block), .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .din_keep(din_keep), .din_last(din_last), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_data(dout_data), .dout_keep(dout_keep), .dout_last(dout_last), .busy(busy),
    .ctr_overflow(ctr_overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [SB_W-1:0] exp_q[$];
  logic [31:0]     ctr_log[$];
  int              rdy_mode   = 0;
  int              resp_delay = 0;
  int              resp_left  = 0;
  logic [31:0]     msg_init   = '0;
  int              beat_idx   = 0;
  logic [DATA_W-1:0] last_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stand-in keystream: word 0 of block 1 is the RFC 8439 sunscreen keystream word.
  function automatic logic [31:0] ks_word(input logic [31:0] ctr, input int i);
    if (ctr == 32'd1 && i == 0) return 32'hf3514f22;
    return (ctr * 32'h9e3779b9) ^ (32'(i) * 32'h85ebca6b) ^ 32'h5bd1e995 ^ {ctr[15:0], ctr[31:16]};
  endfunction

  function automatic logic [511:0] ks_of(input logic [31:0] ctr);
    logic [511:0] b;
    for (int i = 0; i < WORDS; i++) b[i*32 +: 32] = ks_word(ctr, i);
    return b;
  endfunction

  // ---------------- block-function responder ----------------
  initial begin
    ks_valid = 1'b0;
    ks_block = '0;
    forever begin
      @(negedge clk);
      if (ks_req && resp_left > 0 && !rst) begin
        for (int d = 0; d < resp_delay; d++) @(negedge clk);
        if (ks_req && !rst) begin
          ks_valid = 1'b1;
          ks_block = ks_of(ks_counter);
          ctr_log.push_back(ks_counter);
          resp_left--;
          @(negedge clk);
          ks_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    dout_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = 1'($urandom_range(0, 1));
        default: dout_ready = 1'b0;
      endcase
      #1;
      if (!rst && dout_valid && dout_ready) begin
        if (exp_q.size() == 0) check_eq("sb_unexpected_beat", {dout_data, dout_keep, dout_last}, '0);
        else begin
          check_eq("sb_beat", {dout_data, dout_keep, dout_last}, exp_q.pop_front());
          last_data = dout_data;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_msg(input logic [31:0] v);
    @(negedge clk);
    start = 1'b1;
    init_counter = v;
    msg_init = v;
    beat_idx = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k, input logic l);
    int n;
    logic [31:0] ctr;
    logic [KEEP_W-1:0] ke;
    logic [DATA_W-1:0] m;
    @(negedge clk);
    din_valid = 1'b1; din_data = d; din_keep = k; din_last = l;
    n = 0;
    forever begin
      #1;
      if (din_ready) break;
      n++;
      if (n > 200) begin
        check_eq("din_ready_timeout", 0, 1);
        din_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    ctr = msg_init + 32'(beat_idx / WORDS);
    ke  = l ? k : '1;
    for (int b = 0; b < KEEP_W; b++) m[b*8 +: 8] = {8{ke[b]}};
    exp_q.push_back({(d ^ ks_word(ctr, beat_idx % WORDS)) & m, ke, l});
    beat_idx++;
    @(posedge clk);
  endtask

  task automatic end_din();
    @(negedge clk);
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (busy && n < 300);
    check_eq(tag, busy, 0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] v, w;
    logic [SB_W-1:0] snap;
    int n;
    rst = 1'b1; start = 1'b0; init_counter = '0;
    din_valid = 1'b0; din_data = '0; din_keep = '0; din_last = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_ctrl", {ks_req, ks_ready, ks_counter, din_ready, dout_valid, dout_keep,
                            dout_last, busy, ctr_overflow}, '0);
    check_eq("reset_dout_data", dout_data, '0);
    @(negedge clk); rst = 1'b0;

    // RFC 8439 first word: "Ladi" ^ f3514f22
    resp_left = 1000; resp_delay = 0; rdy_mode = 0; ctr_log.delete();
    start_msg(32'd1);
    send_beat(32'h6964614c, 4'hf, 1'b1);
    end_din();
    wait_idle("rfc_idle");
    wait_drain("rfc_drain");
    check_eq("rfc_word", last_data, 32'h9a352e6e);
    check_eq("rfc_first_ctr", ctr_log.size() > 0 ? ctr_log[0] : 32'hdead, 32'd1);

    // 114-byte-style message: 29 beats, partial last beat, random backpressure
    rdy_mode = 1; resp_delay = 2; ctr_log.delete();
    v = $urandom_range(2, 32'h7fff_ffff);
    start_msg(v);
    for (int i = 0; i < 29; i++)
      send_beat($urandom, (i == 28) ? 4'b0011 : 4'($urandom), i == 28);
    end_din();
    wait_idle("long_idle");
    wait_drain("long_drain");
    check_eq("long_nblk", ctr_log.size() >= 2, 1);
    if (ctr_log.size() >= 2) begin
      check_eq("long_ctr0", ctr_log[0], v);
      check_eq("long_ctr1", ctr_log[1], v + 32'd1);
    end

    // dout_ready low for 5 cycles mid-stream
    rdy_mode = 0; resp_delay = 0;
    start_msg($urandom_range(1000, 2000));
    fork
      begin
        for (int i = 0; i < 24; i++) send_beat($urandom, 4'hf, i == 23);
        end_din();
      end
      begin
        n = 0;
        while (beat_idx < 6 && n < 300) begin @(negedge clk); n++; end
        @(posedge clk); #2;
        rdy_mode = 2;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!dout_valid && n < 10);
        check_eq("stall_valid", dout_valid, 1);
        snap = {dout_data, dout_keep, dout_last};
        for (int c = 0; c < 5; c++) begin
          @(negedge clk); #1;
          check_eq("stall_hold", {dout_data, dout_keep, dout_last}, snap);
          check_eq("stall_din_ready", din_ready, 0);
        end
        rdy_mode = 0;
      end
    join
    wait_idle("stall_idle");
    wait_drain("stall_drain");

    // Counter exhaustion at 0xFFFFFFFF
    resp_delay = 1; ctr_log.delete();
    start_msg(32'hffff_ffff);
    for (int i = 0; i < WORDS; i++) send_beat($urandom, 4'hf, 1'b0);
    @(negedge clk); #1;
    check_eq("ovf_flag", ctr_overflow, 1);
    din_valid = 1'b1; din_data = $urandom; din_keep = 4'hf; din_last = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      check_eq("ovf_din_ready", din_ready, 0);
      check_eq("ovf_no_req", ks_req, 0);
    end
    check_eq("ovf_nblk", ctr_log.size(), 1);
    check_eq("ovf_busy", busy, 1);
    din_valid = 1'b0;
    wait_drain("ovf_drain");
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check_eq("ovf_cleared", {ctr_overflow, busy}, 2'b00);

    // din_last on lane 3 with a request outstanding
    resp_delay = 25; ctr_log.delete();
    v = $urandom_range(100, 1000);
    start_msg(v);
    for (int i = 0; i < 4; i++) send_beat($urandom, 4'hf, i == 3);
    end_din();
    #1;
    check_eq("drain_busy_req", {busy, ks_req}, 2'b11);
    wait_idle("drain_idle");
    wait_drain("drain_out");
    check_eq("drain_nblk", ctr_log.size(), 2);
    if (ctr_log.size() == 2) check_eq("drain_ctr1", ctr_log[1], v + 32'd1);
    resp_delay = 0;
    w = v + 32'd500;
    start_msg(w);
    send_beat($urandom, 4'hf, 1'b0);
    send_beat($urandom, 4'h7, 1'b1);
    end_din();
    wait_idle("restart_idle");
    wait_drain("restart_drain");
    check_eq("restart_ctr", ctr_log.size() >= 3 ? ctr_log[2] : 32'hdead, w);

    // Reset mid-message with request outstanding and output held
    rdy_mode = 2; resp_left = 1;
    start_msg(32'd5);
    send_beat($urandom, 4'hf, 1'b0);
    end_din();
    n = 0;
    while (!(ks_req && dout_valid) && n < 40) begin @(negedge clk); #1; n++; end
    check_eq("rst_pre", {ks_req, dout_valid}, 2'b11);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    check_eq("rst_mid_ctrl", {ks_req, ks_ready, ks_counter, din_ready, dout_valid, dout_keep,
                              dout_last, busy, ctr_overflow}, '0);
    check_eq("rst_mid_data", dout_data, '0);
    rst = 1'b0;
    ks_valid = 1'b1; ks_block = {16{32'h1234_5678}};
    @(negedge clk); #1;
    check_eq("rst_late_ks", {ks_counter, ks_req, busy, dout_valid}, '0);
    ks_valid = 1'b0;
    exp_q.delete();
    rdy_mode = 0; resp_left = 1000;

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
